nes_fb_write_arbiter: RTL and testbench

//  Owns the single write port of the 256x240x6b NES frame buffer BRAM and shares it between

---
 rtl/nes_fb_write_arbiter_pkg.sv | 33 +++
 rtl/nes_fb_write_arbiter_clear_seq.sv | 88 ++++++++
 rtl/nes_fb_write_arbiter.sv | 113 +++++++++++
 tb/tb_nes_fb_write_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nes_fb_write_arbiter_pkg.sv
// ============================================================================
// Module  : nes_fb_write_arbiter_pkg
// Brief   : Shared sizes and types for the NES frame buffer write arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package nes_fb_write_arbiter_pkg;

    localparam int FB_W       = 256;
    localparam int FB_H       = 240;
    localparam int ABITS      = 16;
    localparam int CBITS      = 6;
    localparam int COORD_BITS = ABITS / 2;

    typedef logic [ABITS-1:0] fb_addr_t;
    typedef logic [CBITS-1:0] nes_color_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_PPU  = 2'd1,
        GNT_OSD  = 2'd2,
        GNT_CLR  = 2'd3
    } fb_grant_t;

    typedef enum logic {
        CLR_IDLE = 1'b0,
        CLR_RUN  = 1'b1
    } clr_state_t;

endpackage

`default_nettype wire

// File: rtl/nes_fb_write_arbiter_clear_seq.sv
// ============================================================================
// Module  : fb_clear_seq
// Brief   : Row-major full-buffer fill sequencer; advances one pixel per grant.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fb_clear_seq
    import nes_fb_write_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  nes_color_t color,
    input  logic       grant,
    output logic       req,
    output fb_addr_t   addr,
    output nes_color_t data,
    output logic       busy
);

    localparam logic [COORD_BITS-1:0] LAST_COL = COORD_BITS'(FB_W - 1);
    localparam logic [COORD_BITS-1:0] LAST_ROW = COORD_BITS'(FB_H - 1);

    clr_state_t            r_state;
    clr_state_t            w_state_nxt;
    logic [COORD_BITS-1:0] r_row;
    logic [COORD_BITS-1:0] r_col;
    logic [COORD_BITS-1:0] w_row_nxt;
    logic [COORD_BITS-1:0] w_col_nxt;
    nes_color_t            r_color;
    nes_color_t            w_color_nxt;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= CLR_IDLE;
            r_row   <= '0;
            r_col   <= '0;
            r_color <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_row   <= w_row_nxt;
            r_col   <= w_col_nxt;
            r_color <= w_color_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_color_nxt = r_color;
        // A start pulse restarts from the origin even mid-fill.
        if (start) begin
            w_state_nxt = CLR_RUN;
            w_row_nxt   = '0;
            w_col_nxt   = '0;
            w_color_nxt = color;
        end else begin
            case (r_state)
                CLR_RUN: begin
                    if (grant) begin
                        if (r_col == LAST_COL) begin
                            w_col_nxt = '0;
                            if (r_row == LAST_ROW) begin
                                w_row_nxt   = '0;
                                w_state_nxt = CLR_IDLE;
                            end else begin
                                w_row_nxt = r_row + COORD_BITS'(1);
                            end
                        end else begin
                            w_col_nxt = r_col + COORD_BITS'(1);
                        end
                    end
                end
                default: w_state_nxt = r_state;
            endcase
        end
    end

    assign req  = (r_state == CLR_RUN);
    assign busy = (r_state == CLR_RUN);
    assign addr = {r_row, r_col};
    assign data = r_color;

endmodule

`default_nettype wire

// File: rtl/nes_fb_write_arbiter.sv
// ============================================================================
// Module  : nes_fb_write_arbiter
// Brief   : Shares the frame buffer write port between PPU, OSD and clear.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module nes_fb_write_arbiter
    import nes_fb_write_arbiter_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic [CBITS-1:0] color,
    input  logic [8:0]       cycle,
    input  logic [8:0]       scanline,
    input  logic             osd_req,
    input  logic [ABITS-1:0] osd_addr,
    input  logic [CBITS-1:0] osd_wdata,
    output logic             osd_ack,
    input  logic             clr_start,
    input  logic [CBITS-1:0] clr_color,
    output logic             clr_busy,
    output logic             fb_we,
    output logic [ABITS-1:0] fb_addr,
    output logic [CBITS-1:0] fb_wdata
);

    logic [8:0] r_cycle;
    logic [8:0] r_scanline;
    logic       w_pix_vld;
    logic       w_clr_req;
    logic       w_clr_pend;
    fb_addr_t   w_clr_addr;
    nes_color_t w_clr_data;
    fb_grant_t  w_grant;
    logic       w_contested;
    logic       r_rr_osd;

    // Loaded during reset too, so a steady dot position after release is not a new pixel.
    always_ff @(posedge clk) begin
        r_cycle    <= cycle;
        r_scanline <= scanline;
    end

    assign w_pix_vld = ((r_scanline != scanline) || (r_cycle != cycle))
                       && (scanline < 9'(FB_H)) && !cycle[8];

    fb_clear_seq u_clear_seq (
        .clk    (clk),
        .resetn (resetn),
        .start  (clr_start),
        .color  (clr_color),
        .grant  (w_grant == GNT_CLR),
        .req    (w_clr_req),
        .addr   (w_clr_addr),
        .data   (w_clr_data),
        .busy   (clr_busy)
    );

    // A restarting clear issues nothing in the restart cycle.
    assign w_clr_pend  = w_clr_req && !clr_start;
    assign w_contested = !w_pix_vld && osd_req && w_clr_pend;

    always_comb begin
        w_grant = GNT_NONE;
        if (w_pix_vld) begin
            w_grant = GNT_PPU;
        end else if (w_contested) begin
            w_grant = r_rr_osd ? GNT_OSD : GNT_CLR;
        end else if (osd_req) begin
            w_grant = GNT_OSD;
        end else if (w_clr_pend) begin
            w_grant = GNT_CLR;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            fb_we    <= 1'b0;
            fb_addr  <= '0;
            fb_wdata <= '0;
            osd_ack  <= 1'b0;
            r_rr_osd <= 1'b1;
        end else begin
            fb_we   <= (w_grant != GNT_NONE);
            osd_ack <= (w_grant == GNT_OSD);
            if (w_contested) begin
                r_rr_osd <= (w_grant == GNT_CLR);
            end
            case (w_grant)
                GNT_PPU: begin
                    fb_addr  <= {scanline[7:0], cycle[7:0]};
                    fb_wdata <= color;
                end
                GNT_OSD: begin
                    fb_addr  <= osd_addr;
                    fb_wdata <= osd_wdata;
                end
                GNT_CLR: begin
                    fb_addr  <= w_clr_addr;
                    fb_wdata <= w_clr_data;
                end
                default: begin
                    fb_addr  <= fb_addr;
                    fb_wdata <= fb_wdata;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_nes_fb_write_arbiter.sv
// ============================================================================
// Module  : tb_nes_fb_write_arbiter
// Brief   : Self-checking bench for the frame buffer write arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nes_fb_write_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [5:0]  color = '0;
    logic [8:0]  cycle = '0;
    logic [8:0]  scanline = '0;
    logic        osd_req = 1'b0;
    logic [15:0] osd_addr = '0;
    logic [5:0]  osd_wdata = '0;
    logic        osd_ack;
    logic        clr_start = 1'b0;
    logic [5:0]  clr_color = '0;
    logic        clr_busy;
    logic        fb_we;
    logic [15:0] fb_addr;
    logic [5:0]  fb_wdata;

    nes_fb_write_arbiter dut (
        .clk       (clk),
        .resetn    (resetn),
        .color     (color),
        .cycle     (cycle),
        .scanline  (scanline),
        .osd_req   (osd_req),
        .osd_addr  (osd_addr),
        .osd_wdata (osd_wdata),
        .osd_ack   (osd_ack),
        .clr_start (clr_start),
        .clr_color (clr_color),
        .clr_busy  (clr_busy),
        .fb_we     (fb_we),
        .fb_addr   (fb_addr),
        .fb_wdata  (fb_wdata)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: clear progress kept as a linear pixel index.
    int m_pcy = 0, m_psl = 0;
    bit m_busy = 0;
    int m_idx = 0;
    int m_col = 0;
    bit m_rr_osd = 1;
    int m_addr = 0, m_data = 0;
    bit exp_we = 0, exp_ack = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic model_eval();
        int  cy, sl, g;
        bit  pix, cp;
        cy = int'(cycle);
        sl = int'(scanline);
        if (!resetn) begin
            exp_we = 0; exp_ack = 0; m_addr = 0; m_data = 0;
            m_busy = 0; m_idx = 0; m_rr_osd = 1;
        end else begin
            pix = ((sl != m_psl) || (cy != m_pcy)) && (sl < 240) && (cy < 256);
            cp  = m_busy && !clr_start;
            g = 0;
            if (pix) g = 1;
            else if (osd_req && cp) begin
                g = m_rr_osd ? 2 : 3;
                m_rr_osd = (g == 3);
            end else if (osd_req) g = 2;
            else if (cp) g = 3;
            exp_we  = (g != 0);
            exp_ack = (g == 2);
            if (g == 1) begin m_addr = (sl % 256) * 256 + (cy % 256); m_data = int'(color); end
            if (g == 2) begin m_addr = int'(osd_addr); m_data = int'(osd_wdata); end
            if (g == 3) begin m_addr = m_idx; m_data = m_col; end
            if (clr_start) begin
                m_busy = 1; m_idx = 0; m_col = int'(clr_color);
            end else if (g == 3) begin
                m_idx++;
                if (m_idx == 256 * 240) m_busy = 0;
            end
        end
        m_pcy = cy;
        m_psl = sl;
    endtask

    task automatic step();
        model_eval();
        @(posedge clk);
        #1;
        chk("fb_we", int'(fb_we), int'(exp_we));
        chk("fb_addr", int'(fb_addr), m_addr);
        chk("fb_wdata", int'(fb_wdata), m_data);
        chk("osd_ack", int'(osd_ack), int'(exp_ack));
        chk("clr_busy", int'(clr_busy), int'(m_busy));
    endtask

    task automatic do_reset();
        resetn = 1'b0; osd_req = 1'b0; clr_start = 1'b0;
        step(); step();
        resetn = 1'b1;
    endtask

    typedef struct {
        int cy; int sl; int col;
        bit we; int addr; int data;
    } vec_t;
    vec_t tbl[12];

    logic seen [0:65535];

    initial begin
        int n, cnt, dup, first, last, acks, clrw;

        tbl[0]  = '{37, 5, 1, 0, 16'h0000, 0};
        tbl[1]  = '{37, 5, 1, 0, 16'h0000, 0};
        tbl[2]  = '{38, 5, 3, 1, 16'h0526, 3};
        tbl[3]  = '{38, 5, 3, 0, 16'h0526, 3};
        tbl[4]  = '{255, 5, 7, 1, 16'h05FF, 7};
        tbl[5]  = '{256, 5, 8, 0, 16'h05FF, 7};
        tbl[6]  = '{0, 239, 9, 1, 16'hEF00, 9};
        tbl[7]  = '{0, 240, 9, 0, 16'hEF00, 9};
        tbl[8]  = '{1, 240, 9, 0, 16'hEF00, 9};
        tbl[9]  = '{1, 261, 9, 0, 16'hEF00, 9};
        tbl[10] = '{0, 0, 63, 1, 16'h0000, 63};
        tbl[11] = '{340, 0, 5, 0, 16'h0000, 63};

        // Reset release with a steady dot position, then the vector table.
        cycle = 9'd37; scanline = 9'd5;
        do_reset();
        chk("reset_we", int'(fb_we), 0);
        chk("reset_busy", int'(clr_busy), 0);
        foreach (tbl[i]) begin
            cycle = 9'(tbl[i].cy); scanline = 9'(tbl[i].sl); color = 6'(tbl[i].col);
            step();
            chk($sformatf("tbl%0d_we", i), int'(fb_we), int'(tbl[i].we));
            chk($sformatf("tbl%0d_addr", i), int'(fb_addr), tbl[i].addr);
            chk($sformatf("tbl%0d_data", i), int'(fb_wdata), tbl[i].data);
        end

        // PPU sweep across one visible line.
        cycle = 9'd300; scanline = 9'd10;
        step(); step();
        cnt = 0; first = -1; last = -1;
        for (int c = 0; c < 256; c++) begin
            cycle = 9'(c); color = 6'(c);
            for (int k = 0; k < 4; k++) begin
                step();
                if (fb_we) begin
                    cnt++;
                    if (first < 0) first = int'(fb_addr);
                    last = int'(fb_addr);
                end
            end
        end
        chk("ppu_line_writes", cnt, 256);
        chk("ppu_first_addr", first, 16'h0A00);
        chk("ppu_last_addr", last, 16'h0AFF);

        // OSD request colliding with a pixel.
        cycle = 9'd4; scanline = 9'd20;
        step(); step();
        cycle = 9'd5; osd_req = 1'b1; osd_addr = 16'h1234; osd_wdata = 6'h2A;
        step();
        chk("coll_ppu_addr", int'(fb_addr), 16'h1405);
        chk("coll_ppu_ack", int'(osd_ack), 0);
        step();
        chk("coll_osd_ack", int'(osd_ack), 1);
        chk("coll_osd_addr", int'(fb_addr), 16'h1234);
        chk("coll_osd_data", int'(fb_wdata), 6'h2A);
        osd_req = 1'b0;
        acks = 0;
        for (int k = 0; k < 5; k++) begin step(); acks += int'(osd_ack); end
        chk("coll_extra_acks", acks, 0);

        // Full clear with the PPU idle.
        for (int a = 0; a < 65536; a++) seen[a] = 1'b0;
        clr_color = 6'h0F; clr_start = 1'b1;
        step();
        clr_start = 1'b0; clr_color = 6'h00;
        n = 0; cnt = 0; dup = 0; first = -1; last = -1;
        do begin
            step();
            n++;
            if (fb_we) begin
                if (seen[fb_addr]) dup++;
                seen[fb_addr] = 1'b1;
                cnt++;
                if (first < 0) first = int'(fb_addr);
                last = int'(fb_addr);
            end
        end while (clr_busy && n < 70000);
        chk("clr_timeout_busy", int'(clr_busy), 0);
        chk("clr_write_count", cnt, 61440);
        chk("clr_duplicates", dup, 0);
        chk("clr_first_addr", first, 0);
        chk("clr_last_addr", last, 16'hEFFF);
        chk("clr_last_data", int'(fb_wdata), 6'h0F);

        // Clear sharing with a continuous OSD stream.
        do_reset();
        osd_req = 1'b1; osd_addr = 16'h2000; osd_wdata = 6'h11;
        clr_color = 6'h05; clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        acks = 0; clrw = 0;
        for (int k = 0; k < 400; k++) begin
            step();
            if (osd_ack) begin
                acks++;
                osd_addr = 16'($urandom_range(0, 65535));
                osd_wdata = 6'($urandom_range(0, 63));
            end else if (fb_we) clrw++;
        end
        chk("share_osd_acks", acks, 200);
        chk("share_clr_writes", clrw, 200);
        osd_req = 1'b0;

        // Restart at 0x0300, then abort with reset.
        do_reset();
        clr_color = 6'h0F; clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        n = 0;
        while (m_idx < 16'h0300 && n < 2000) begin step(); n++; end
        chk("restart_reach", m_idx, 16'h0300);
        clr_color = 6'h21; clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        chk("restart_no_write", int'(fb_we), 0);
        chk("restart_busy", int'(clr_busy), 1);
        step();
        chk("restart_addr", int'(fb_addr), 0);
        chk("restart_data", int'(fb_wdata), 6'h21);
        for (int k = 0; k < 50; k++) step();
        resetn = 1'b0;
        step();
        chk("abort_busy", int'(clr_busy), 0);
        chk("abort_we", int'(fb_we), 0);
        resetn = 1'b1;
        cnt = 0;
        for (int k = 0; k < 20; k++) begin step(); cnt += int'(fb_we); end
        chk("abort_no_writes", cnt, 0);

        // Randomized traffic against the model.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                cycle = 9'($urandom_range(0, 340));
                scanline = 9'($urandom_range(0, 261));
                color = 6'($urandom_range(0, 63));
            end
            clr_start = ($urandom_range(0, 499) == 0);
            clr_color = 6'($urandom_range(0, 63));
            resetn = ($urandom_range(0, 999) != 0);
            if (!resetn) osd_req = 1'b0;
            step();
            clr_start = 1'b0;
            if (osd_req && osd_ack) begin
                if ($urandom_range(0, 1) == 0) osd_req = 1'b0;
                else begin
                    osd_addr = 16'($urandom_range(0, 65535));
                    osd_wdata = 6'($urandom_range(0, 63));
                end
            end else if (!osd_req && $urandom_range(0, 3) == 0) begin
                osd_req = 1'b1;
                osd_addr = 16'($urandom_range(0, 65535));
                osd_wdata = 6'($urandom_range(0, 63));
            end
        end
        resetn = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
